lcd_fill_sched: RTL and testbench
=================================

# lcd_fill_sched

Line-fill scheduler for the LCD pixel path. On each horizontal line it sequences the writing of `LINE_BYTES` pixels into the downstream line FIFO, and honours FIFO backpressure. It also arbitrates the single-port image ROM between two sprite layers, with sprite 0 taking priority. It sits between the HSYNC/VSYNC timing source and the line FIFO, drives the ImgROM address port, and replaces free-running write enables with a stall-aware, abortable fill.

## Interface
- `LINE_BYTES`, 1600: FIFO writes per line.
- `FRAME_LINES`, 240: lines filled per frame; further HSYNCs are ignored until the next VSYNC.
- `SPR_W`, 256 / `SPR_H`, 128: sprite size; the ROM image is `SPR_H` × `SPR_W` bytes.
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `HSYNC` in 1: active-high line blanking.
- `VSYNC` in 1: active-high frame blanking.
- `FIFOAFull` in 1: FIFO almost-full; at least 2 free entries remain when it asserts.
- `SprEn` in 2: per-sprite enable.
- `SprX0`, `SprX1` in 16: sprite left edge, in pixel units.
- `SprY0`, `SprY1` in 16: sprite top line.
- `RomAddr` out 15: ImgROM address.
- `RomData` in 8: ImgROM data, one cycle after the address.
- `FIFOWe` out 1: FIFO write strobe.
- `RGBData` out 8: FIFO write data.
- `LineCount` out 16: lines completed or aborted this frame.
- `Busy` out 1: high in FILL and HOLD.
- `Overrun` out 1: one-cycle pulse when a line is aborted.

## Operation
- States:
  - IDLE: after reset, while VSYNC is high, and after `FRAME_LINES` lines.
  - WAIT_H: armed for the next line.
  - FILL: issuing pixels.
  - HOLD: backpressure.
- Transitions:
  - IDLE → WAIT_H on VSYNC falling (sampled).
  - WAIT_H → FILL on HSYNC falling (`hs_q`=1, `HSYNC`=0).
  - FILL → HOLD while `FIFOAFull`=1; HOLD → FILL when it clears.
  - FILL → WAIT_H after pixel `LINE_BYTES-1` is issued.
  - Any state → IDLE while `VSYNC`=1.
  - WAIT_H → IDLE when `LineCount` reaches `FRAME_LINES`.
- Line counting: `LineCount` increments when a line finishes or is aborted. It clears while VSYNC is high.
- Sprite register latching: `SprEn`/`SprX*`/`SprY*` are latched every cycle while VSYNC is high and are frozen otherwise.
- Pixel X counter (11+ bits):
  - resets to 0 on FILL entry;
  - increments once per FILL cycle;
  - holds in HOLD.
- Coverage of sprite k at pixel (X, L=`LineCount`):
  - condition: `SprEn[k]` & X≥SprXk & X<SprXk+`SPR_W` & L≥SprYk & L<SprYk+`SPR_H`;
  - all sums are computed at 17 bits, so there is no wraparound.
- Arbitration:
  - sprite 0 wins if it covers the pixel, else sprite 1 if it covers, else none;
  - `RomAddr` = {(L−SprY)[6:0], (X−SprX)[7:0]} of the winner;
  - with no winner, `RomAddr` is 0.
- Output data: `RGBData` = `RomData` if the stage-1 winner is valid, else 8'hFF.
- Abort:
  - HSYNC rising while in FILL or HOLD causes an `Overrun` pulse, increments `LineCount`, drops the remaining pixels, and moves to WAIT_H;
  - the in-flight stage-1 pixel is still written.
- VSYNC mid-line:
  - `FIFOWe` is forced to 0 combinationally while VSYNC is high;
  - stage-1 valid clears;
  - no `Overrun` pulse.

## Timing
- Reset values: `FIFOWe`=0, `RGBData`=8'hFF, `RomAddr`=0, `LineCount`=0, `Busy`=0, `Overrun`=0; state is IDLE.
- Two-stage pipeline:
  - stage 0 (issue): `RomAddr` is driven in the issue cycle;
  - stage 1 (write): `FIFOWe`/`RGBData` appear the next cycle.
- HSYNC sampled low at cycle t: FILL and pixel 0 issue at t+1; the first `FIFOWe` is at t+2.
- Uninterrupted line: exactly `LINE_BYTES` contiguous `FIFOWe` cycles. The last write is at t+1+`LINE_BYTES`.
- Backpressure: `FIFOAFull` sampled high at cycle c means no issue in c; at most one write (the in-flight one) occurs at c+1.
- Pixel order is strictly ascending X. Each pixel is written at most once.

## Structure
- A shared package `lcd_pkg` holds:
  - the state enum;
  - `LINE_BYTES`, `FRAME_LINES`, `SPR_W`, `SPR_H` defaults;
  - the background colour 8'hFF.
- One sub-module, `spr_hit`, is instantiated twice. It is combinational coverage plus local-address generation per sprite.
- The FSM, the X counter and the pipeline stay in the top level.

## Test plan
- Reset: assert `nRST`=0 mid-FILL → all outputs at their reset values immediately. After release, state is IDLE and no writes occur until VSYNC→HSYNC.
- No sprites: VSYNC pulse, then one HSYNC pulse → 1600 contiguous writes of 8'hFF starting 2 cycles after HSYNC falls; `LineCount`=1.
- Sprite 0 only, `SprX0`=100, `SprY0`=0, line 0 → X 100..355 carry `RomData` for `RomAddr` 0..255 in order; the rest is 8'hFF.
- Overlap: sprite 0 at (100,0), sprite 1 at (200,0), line 0 → X 200..355 use sprite 0 addresses 100..255; X 356..455 use sprite 1 addresses 156..255.
- Backpressure: `FIFOAFull`=1 for 10 cycles starting at X=500 → exactly one write during the hold, 1600 total, with no gaps or duplicates in X order.
- Abort and frame end:
  - HSYNC rises at X=800 → one `Overrun` pulse, 801 writes, `LineCount`+1, and the next line fills fully;
  - after 240 lines, further HSYNCs produce no writes until VSYNC.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and defaults for the LCD line-fill scheduler.
// No logic: constants and the scheduler state enum only.
// Consumers: lcd_fill_sched, spr_hit.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_H = 2'd1,
    ST_FILL   = 2'd2,
    ST_HOLD   = 2'd3
  } fill_state_t;

  localparam int DEF_LINE_BYTES  = 1600;
  localparam int DEF_FRAME_LINES = 240;
  localparam int DEF_SPR_W       = 256;
  localparam int DEF_SPR_H       = 128;

  // Pixel colour written where no sprite covers the pixel
  localparam logic [7:0] BG_COLOUR = 8'hFF;

endpackage

// File: rtl/lcd_fill_sched_if.sv
// Bus bundle between the timing source, ImgROM, line FIFO and the fill scheduler.
// Latency: none, wires only.
// Backpressure: carried by FIFOAFull from the line FIFO side.
interface lcd_fill_sched_if;
  logic        HSYNC;
  logic        VSYNC;
  logic        FIFOAFull;
  logic [1:0]  SprEn;
  logic [15:0] SprX0;
  logic [15:0] SprX1;
  logic [15:0] SprY0;
  logic [15:0] SprY1;
  logic [14:0] RomAddr;
  logic [7:0]  RomData;
  logic        FIFOWe;
  logic [7:0]  RGBData;
  logic [15:0] LineCount;
  logic        Busy;
  logic        Overrun;

  // Scheduler side: drives the ROM address and the FIFO write port
  modport master (
    input  HSYNC, VSYNC, FIFOAFull, SprEn, SprX0, SprX1, SprY0, SprY1, RomData,
    output RomAddr, FIFOWe, RGBData, LineCount, Busy, Overrun
  );

  // Environment side: timing source, sprite registers, ROM and FIFO
  modport slave (
    output HSYNC, VSYNC, FIFOAFull, SprEn, SprX0, SprX1, SprY0, SprY1, RomData,
    input  RomAddr, FIFOWe, RGBData, LineCount, Busy, Overrun
  );
endinterface

// File: rtl/lcd_fill_sched_spr_hit.sv
// Sprite coverage test and sprite-local ROM address for one pixel.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module spr_hit
  import lcd_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  logic        en,
  input  logic [15:0] x,
  input  logic [15:0] line,
  input  logic [15:0] spr_x,
  input  logic [15:0] spr_y,
  output logic        hit,
  output logic [14:0] addr
);

  logic [16:0] x_end;
  logic [16:0] y_end;
  logic        in_x;
  logic        in_y;
  logic [7:0]  dx;
  logic [6:0]  dy;

  // Window compare at 17 bits so a sprite near 16'hFFFF never wraps; the
  // address only needs the low bits of the offsets
  always_comb begin
    x_end = {1'b0, spr_x} + 17'(SPR_W);
    y_end = {1'b0, spr_y} + 17'(SPR_H);
    in_x  = ({1'b0, x} >= {1'b0, spr_x}) && ({1'b0, x} < x_end);
    in_y  = ({1'b0, line} >= {1'b0, spr_y}) && ({1'b0, line} < y_end);
    hit   = en && in_x && in_y;
    dx    = x[7:0] - spr_x[7:0];
    dy    = line[6:0] - spr_y[6:0];
    addr  = {dy, dx};
  end

endmodule

// File: rtl/lcd_fill_sched.sv
// Per-line pixel fill into the line FIFO with two-layer sprite ROM arbitration.
// Latency: ROM address in the issue cycle, FIFO write one cycle later.
// Backpressure: FIFOAFull stops issue in the same cycle; only the in-flight pixel is written.
module lcd_fill_sched
  import lcd_pkg::*;
#(
  parameter int LINE_BYTES  = DEF_LINE_BYTES,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H
) (
  input logic              CLK,
  input logic              nRST,
  lcd_fill_sched_if.master bus
);

  fill_state_t state;
  fill_state_t state_nxt;

  logic        hs_q;
  logic        vs_q;
  logic [1:0]  spr_en;
  logic [15:0] spr_x0;
  logic [15:0] spr_x1;
  logic [15:0] spr_y0;
  logic [15:0] spr_y1;
  logic [15:0] xcnt;
  logic [15:0] line_cnt;
  logic        s1_vld;
  logic        s1_hit;
  logic        ovr_q;

  logic        hit0;
  logic        hit1;
  logic [14:0] addr0;
  logic [14:0] addr1;

  logic        filling;
  logic        issue;
  logic        last_px;
  logic        abort;

  spr_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit0 (
    .en(spr_en[0]), .x(xcnt), .line(line_cnt), .spr_x(spr_x0), .spr_y(spr_y0),
    .hit(hit0), .addr(addr0)
  );

  spr_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit1 (
    .en(spr_en[1]), .x(xcnt), .line(line_cnt), .spr_x(spr_x1), .spr_y(spr_y1),
    .hit(hit1), .addr(addr1)
  );

  // A pixel issues only in FILL with room downstream and outside frame blanking;
  // a rising HSYNC still lets the current pixel issue, then ends the line
  assign filling = (state == ST_FILL) || (state == ST_HOLD);
  assign issue   = (state == ST_FILL) && !bus.FIFOAFull && !bus.VSYNC;
  assign last_px = issue && (xcnt == 16'(LINE_BYTES - 1));
  assign abort   = filling && bus.HSYNC && !hs_q && !bus.VSYNC;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; VSYNC overrides everything
  always_comb begin
    state_nxt = state;
    if (bus.VSYNC) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (vs_q) state_nxt = ST_WAIT_H;
        ST_WAIT_H: begin
          if (line_cnt >= 16'(FRAME_LINES)) state_nxt = ST_IDLE;
          else if (hs_q && !bus.HSYNC)      state_nxt = ST_FILL;
        end
        ST_FILL: begin
          if (abort || last_px)   state_nxt = ST_WAIT_H;
          else if (bus.FIFOAFull) state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          if (abort)               state_nxt = ST_WAIT_H;
          else if (!bus.FIFOAFull) state_nxt = ST_FILL;
        end
        default:                 state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sync edge history and sprite registers, which only follow inputs during VSYNC
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      spr_en <= '0;
      spr_x0 <= '0;
      spr_x1 <= '0;
      spr_y0 <= '0;
      spr_y1 <= '0;
    end else begin
      hs_q <= bus.HSYNC;
      vs_q <= bus.VSYNC;
      if (bus.VSYNC) begin
        spr_en <= bus.SprEn;
        spr_x0 <= bus.SprX0;
        spr_x1 <= bus.SprX1;
        spr_y0 <= bus.SprY0;
        spr_y1 <= bus.SprY1;
      end
    end
  end

  // X counter starts each line at 0 and advances once per issued pixel
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        xcnt <= '0;
    else if (!filling) xcnt <= '0;
    else if (issue)    xcnt <= xcnt + 16'd1;
  end

  // Lines completed or aborted in this frame
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                    line_cnt <= '0;
    else if (bus.VSYNC)           line_cnt <= '0;
    else if (last_px || abort)    line_cnt <= line_cnt + 16'd1;
  end

  // Write stage: remembers whether the issued pixel came from a sprite
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      s1_vld <= issue;
      s1_hit <= issue && (hit0 || hit1);
      ovr_q  <= abort;
    end
  end

  // Outputs; sprite 0 has priority on the shared ROM port
  always_comb begin
    bus.Busy      = filling;
    bus.FIFOWe    = s1_vld && !bus.VSYNC;
    bus.RGBData   = s1_hit ? bus.RomData : BG_COLOUR;
    bus.LineCount = line_cnt;
    bus.Overrun   = ovr_q;
    bus.RomAddr   = '0;
    if (issue) begin
      if (hit0)      bus.RomAddr = addr0;
      else if (hit1) bus.RomAddr = addr1;
    end
  end

endmodule

// File: tb/tb_lcd_fill_sched.sv
// Self-checking bench for lcd_fill_sched against a per-pixel reference model.
// Inputs change 2 time units after the rising edge; outputs are captured on the falling edge.
// Drives FIFOAFull, HSYNC aborts and VSYNC directly to exercise stalls and frame control.
module tb_lcd_fill_sched;
  import lcd_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  lcd_fill_sched_if ifc ();
  lcd_fill_sched dut (.CLK(CLK), .nRST(nRST), .bus(ifc));

  logic [7:0] rom [32768];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [7:0] wq[$];
  int wc[$];
  int ovr = 0;

  bit [1:0] m_en;
  int m_x0, m_x1, m_y0, m_y1;

  // ROM model: data one cycle after the address
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    ifc.RomData <= rom[ifc.RomAddr];
  end

  // Capture every FIFO write with its cycle number, and count Overrun pulses
  always @(negedge CLK) begin
    if (ifc.FIFOWe === 1'b1) begin
      wq.push_back(ifc.RGBData);
      wc.push_back(cyc);
    end
    if (ifc.Overrun === 1'b1) ovr++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic int exp_pix(int x, int l);
    if (m_en[0] && x >= m_x0 && x < m_x0 + 256 && l >= m_y0 && l < m_y0 + 128)
      return int'(rom[(l - m_y0) * 256 + (x - m_x0)]);
    if (m_en[1] && x >= m_x1 && x < m_x1 + 256 && l >= m_y1 && l < m_y1 + 128)
      return int'(rom[(l - m_y1) * 256 + (x - m_x1)]);
    return 255;
  endfunction

  function automatic int count_bad(int l);
    int n = 0;
    foreach (wq[i]) if (wq[i] !== 8'(exp_pix(i, l))) n++;
    return n;
  endfunction

  task automatic clear_cap();
    wq.delete();
    wc.delete();
  endtask

  // Latch a sprite setup during a VSYNC pulse, then scramble the inputs to prove they are frozen
  task automatic vsync(input bit [1:0] en, input int x0, input int y0, input int x1, input int y1);
    ifc.SprEn = en;
    ifc.SprX0 = 16'(x0); ifc.SprY0 = 16'(y0);
    ifc.SprX1 = 16'(x1); ifc.SprY1 = 16'(y1);
    ifc.VSYNC = 1'b1;
    repeat (3) tick();
    ifc.VSYNC = 1'b0;
    m_en = en; m_x0 = x0; m_y0 = y0; m_x1 = x1; m_y1 = y1;
    ifc.SprEn = 2'($urandom);
    ifc.SprX0 = 16'($urandom); ifc.SprY0 = 16'($urandom);
    ifc.SprX1 = 16'($urandom); ifc.SprY1 = 16'($urandom);
    repeat (2) tick();
  endtask

  // One HSYNC pulse and the resulting fill; optional abort and backpressure hooks keyed on writes seen
  task automatic run_line(input int abort_at, input int af_at, output int fall_c, output int hold_c);
    bit done = 0;
    bit ab = 0;
    bit af = 0;
    int af_left = 0;
    hold_c = -1;
    ifc.HSYNC = 1'b1;
    repeat (2) tick();
    ifc.HSYNC = 1'b0;
    fall_c = cyc;
    for (int i = 0; i < 5000 && !done; i++) begin
      tick();
      if (abort_at >= 0 && !ab && wq.size() == abort_at) begin
        ifc.HSYNC = 1'b1;
        ab = 1;
      end
      if (af_at >= 0 && !af && wq.size() == af_at) begin
        ifc.FIFOAFull = 1'b1;
        af = 1;
        hold_c = cyc;
        af_left = 10;
      end else if (af_left > 0) begin
        af_left--;
        if (af_left == 0) ifc.FIFOAFull = 1'b0;
      end
      if (cyc > fall_c + 2 && ifc.Busy == 1'b0) done = 1;
    end
    repeat (3) tick();
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL line_timeout: Busy still %0b, required 0 within 5000 cycles", ifc.Busy);
    end
  endtask

  task automatic test_reset();
    int fc, hc;
    repeat (3) tick();
    tests++; if (ifc.FIFOWe !== 1'b0) begin fails++; $display("FAIL rst_fifowe: got %0b exp 0", ifc.FIFOWe); end
    tests++; if (ifc.RGBData !== 8'hFF) begin fails++; $display("FAIL rst_rgb: got %0h exp ff", ifc.RGBData); end
    tests++; if (ifc.RomAddr !== 15'd0) begin fails++; $display("FAIL rst_romaddr: got %0h exp 0", ifc.RomAddr); end
    tests++; if (ifc.LineCount !== 16'd0) begin fails++; $display("FAIL rst_linecount: got %0d exp 0", ifc.LineCount); end
    tests++; if (ifc.Busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b exp 0", ifc.Busy); end
    tests++; if (ifc.Overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %0b exp 0", ifc.Overrun); end
    nRST = 1'b1;
    tick();
    // No VSYNC yet: HSYNC alone must not start a fill
    clear_cap();
    ifc.HSYNC = 1'b1; repeat (2) tick(); ifc.HSYNC = 1'b0; repeat (20) tick();
    tests++; if (wq.size() != 0) begin fails++; $display("FAIL rst_no_vsync_writes: got %0d exp 0", wq.size()); end
    // Reset asserted in the middle of a fill
    vsync(2'b01, 10, 0, 0, 0);
    ifc.HSYNC = 1'b1; repeat (2) tick(); ifc.HSYNC = 1'b0; repeat (50) tick();
    tests++; if (ifc.Busy !== 1'b1) begin fails++; $display("FAIL midfill_busy: got %0b exp 1", ifc.Busy); end
    nRST = 1'b0;
    #1;
    tests++; if (ifc.FIFOWe !== 1'b0) begin fails++; $display("FAIL midrst_fifowe: got %0b exp 0", ifc.FIFOWe); end
    tests++; if (ifc.RGBData !== 8'hFF) begin fails++; $display("FAIL midrst_rgb: got %0h exp ff", ifc.RGBData); end
    tests++; if (ifc.RomAddr !== 15'd0) begin fails++; $display("FAIL midrst_romaddr: got %0h exp 0", ifc.RomAddr); end
    tests++; if (ifc.LineCount !== 16'd0) begin fails++; $display("FAIL midrst_linecount: got %0d exp 0", ifc.LineCount); end
    tests++; if (ifc.Busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %0b exp 0", ifc.Busy); end
    tick();
    nRST = 1'b1;
    tick();
    clear_cap();
    run_line(-1, -1, fc, hc);
    tests++; if (wq.size() != 0) begin fails++; $display("FAIL postrst_writes: got %0d exp 0", wq.size()); end
  endtask

  task automatic test_no_sprites();
    int fc, hc;
    vsync(2'b00, 0, 0, 0, 0);
    tests++; if (ifc.LineCount !== 16'd0) begin fails++; $display("FAIL ns_lc_clear: got %0d exp 0", ifc.LineCount); end
    clear_cap();
    ovr = 0;
    run_line(-1, -1, fc, hc);
    tests++; if (wq.size() != 1600) begin fails++; $display("FAIL ns_count: got %0d exp 1600", wq.size()); end
    tests++; if (wq.size() > 0 && wc[0] != fc + 2) begin fails++; $display("FAIL ns_first_cycle: got %0d exp %0d", wc[0], fc + 2); end
    tests++; if (wq.size() > 0 && wc[wc.size()-1] != fc + 1601) begin fails++; $display("FAIL ns_last_cycle: got %0d exp %0d", wc[wc.size()-1], fc + 1601); end
    tests++; if (count_bad(0) != 0) begin fails++; $display("FAIL ns_data: got %0d bad pixels exp 0", count_bad(0)); end
    tests++; if (ifc.LineCount !== 16'd1) begin fails++; $display("FAIL ns_linecount: got %0d exp 1", ifc.LineCount); end
    tests++; if (ovr != 0) begin fails++; $display("FAIL ns_overrun: got %0d exp 0", ovr); end
  endtask

  task automatic test_sprite0();
    int fc, hc;
    vsync(2'b01, 100, 0, 0, 0);
    clear_cap();
    run_line(-1, -1, fc, hc);
    tests++; if (wq.size() != 1600) begin fails++; $display("FAIL s0_count: got %0d exp 1600", wq.size()); end
    tests++; if (count_bad(0) != 0) begin fails++; $display("FAIL s0_data: got %0d bad pixels exp 0", count_bad(0)); end
    tests++; if (wq.size() == 1600 && (wq[100] !== rom[0] || wq[355] !== rom[255] || wq[99] !== 8'hFF || wq[356] !== 8'hFF))
      begin fails++; $display("FAIL s0_edges: got %0h %0h %0h %0h exp ff %0h %0h ff", wq[99], wq[100], wq[355], wq[356], rom[0], rom[255]); end
  endtask

  task automatic test_overlap();
    int fc, hc;
    vsync(2'b11, 100, 0, 200, 0);
    clear_cap();
    run_line(-1, -1, fc, hc);
    tests++; if (wq.size() != 1600) begin fails++; $display("FAIL ov_count: got %0d exp 1600", wq.size()); end
    tests++; if (count_bad(0) != 0) begin fails++; $display("FAIL ov_data: got %0d bad pixels exp 0", count_bad(0)); end
    tests++; if (wq.size() == 1600 && (wq[200] !== rom[100] || wq[356] !== rom[156] || wq[455] !== rom[255] || wq[456] !== 8'hFF))
      begin fails++; $display("FAIL ov_edges: got %0h %0h %0h %0h exp %0h %0h %0h ff", wq[200], wq[356], wq[455], wq[456], rom[100], rom[156], rom[255]); end
  endtask

  task automatic test_backpressure();
    int fc, hc, in_hold;
    vsync(2'b11, int'($urandom_range(300, 600)), 0, int'($urandom_range(0, 1400)), 0);
    clear_cap();
    run_line(-1, 500, fc, hc);
    in_hold = 0;
    foreach (wc[i]) if (wc[i] >= hc && wc[i] <= hc + 9) in_hold++;
    tests++; if (in_hold != 1) begin fails++; $display("FAIL bp_hold_writes: got %0d exp 1", in_hold); end
    tests++; if (wq.size() != 1600) begin fails++; $display("FAIL bp_count: got %0d exp 1600", wq.size()); end
    tests++; if (count_bad(0) != 0) begin fails++; $display("FAIL bp_data: got %0d bad pixels exp 0", count_bad(0)); end
  endtask

  task automatic test_abort();
    int fc, hc;
    vsync(2'b01, 700, 0, 0, 0);
    clear_cap();
    ovr = 0;
    run_line(799, -1, fc, hc);
    tests++; if (wq.size() != 801) begin fails++; $display("FAIL ab_count: got %0d exp 801", wq.size()); end
    tests++; if (count_bad(0) != 0) begin fails++; $display("FAIL ab_data: got %0d bad pixels exp 0", count_bad(0)); end
    tests++; if (ovr != 1) begin fails++; $display("FAIL ab_overrun: got %0d exp 1", ovr); end
    tests++; if (ifc.LineCount !== 16'd1) begin fails++; $display("FAIL ab_linecount: got %0d exp 1", ifc.LineCount); end
    clear_cap();
    run_line(-1, -1, fc, hc);
    tests++; if (wq.size() != 1600) begin fails++; $display("FAIL ab_next_count: got %0d exp 1600", wq.size()); end
    tests++; if (count_bad(1) != 0) begin fails++; $display("FAIL ab_next_data: got %0d bad pixels exp 0", count_bad(1)); end
    tests++; if (ifc.LineCount !== 16'd2 || ovr != 1) begin fails++; $display("FAIL ab_next_lc: got lc %0d ovr %0d exp lc 2 ovr 1", ifc.LineCount, ovr); end
  endtask

  task automatic test_random();
    int fc, hc;
    for (int k = 0; k < 3; k++) begin
      vsync(2'($urandom), int'($urandom_range(0, 1700)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 1700)), int'($urandom_range(0, 2)));
      for (int l = 0; l < 3; l++) begin
        clear_cap();
        run_line(-1, -1, fc, hc);
        tests++; if (wq.size() != 1600 || count_bad(l) != 0)
          begin fails++; $display("FAIL rnd_line: cfg %0d line %0d got %0d writes %0d bad exp 1600 0", k, l, wq.size(), count_bad(l)); end
      end
    end
  endtask

  task automatic test_vsync_midline();
    int ovr0;
    vsync(2'b00, 0, 0, 0, 0);
    ifc.HSYNC = 1'b1; repeat (2) tick(); ifc.HSYNC = 1'b0; repeat (30) tick();
    ovr0 = ovr;
    ifc.VSYNC = 1'b1;
    #1;
    tests++; if (ifc.FIFOWe !== 1'b0) begin fails++; $display("FAIL vs_fifowe: got %0b exp 0", ifc.FIFOWe); end
    repeat (2) tick();
    tests++; if (ifc.Busy !== 1'b0 || ifc.LineCount !== 16'd0) begin fails++; $display("FAIL vs_state: got busy %0b lc %0d exp 0 0", ifc.Busy, ifc.LineCount); end
    tests++; if (ovr != ovr0) begin fails++; $display("FAIL vs_overrun: got %0d exp %0d", ovr, ovr0); end
    ifc.VSYNC = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_frame_end();
    int fc, hc;
    vsync(2'b00, 0, 0, 0, 0);
    ovr = 0;
    for (int n = 0; n < 240; n++) begin
      ifc.HSYNC = 1'b1; tick();
      ifc.HSYNC = 1'b0; repeat (3) tick();
      ifc.HSYNC = 1'b1; repeat (2) tick();
    end
    tick();
    tests++; if (ifc.LineCount !== 16'd240) begin fails++; $display("FAIL fe_linecount: got %0d exp 240", ifc.LineCount); end
    tests++; if (ovr != 240) begin fails++; $display("FAIL fe_overruns: got %0d exp 240", ovr); end
    clear_cap();
    ifc.HSYNC = 1'b1; repeat (2) tick(); ifc.HSYNC = 1'b0; repeat (40) tick();
    tests++; if (wq.size() != 0 || ifc.Busy !== 1'b0) begin fails++; $display("FAIL fe_extra_line: got %0d writes busy %0b exp 0 0", wq.size(), ifc.Busy); end
    vsync(2'b00, 0, 0, 0, 0);
    clear_cap();
    run_line(-1, -1, fc, hc);
    tests++; if (wq.size() != 1600) begin fails++; $display("FAIL fe_new_frame: got %0d exp 1600", wq.size()); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 8'($urandom_range(0, 254));
    nRST = 1'b0;
    ifc.HSYNC = 1'b0;
    ifc.VSYNC = 1'b0;
    ifc.FIFOAFull = 1'b0;
    ifc.SprEn = 2'b00;
    ifc.SprX0 = '0; ifc.SprX1 = '0; ifc.SprY0 = '0; ifc.SprY1 = '0;
    test_reset();
    test_no_sprites();
    test_sprite0();
    test_overlap();
    test_backpressure();
    test_abort();
    test_random();
    test_vsync_midline();
    test_frame_end();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
